// File: rtl/vga_pkg.sv
// Shared types and widths for the VGA drawing pipeline.
package vga_pkg;

  localparam int unsigned CFG_DATA_W  = 12;
  localparam int unsigned COLOR_W     = 12;
  localparam int unsigned POS_W       = 12;
  localparam int unsigned FRAME_CNT_W = 16;

  // Config register map seen by the mouse/UART write source.
  typedef enum logic [1:0] {
    CFG_FRAME_COLOR = 2'd0,
    CFG_RECT_X      = 2'd1,
    CFG_RECT_Y      = 2'd2,
    CFG_RSVD        = 2'd3
  } cfg_addr_e;

endpackage

// File: rtl/vga_if.sv
// VGA timing bus; this slice of the pipeline only needs vertical blanking.
interface vga_if;

  logic vblnk;

  modport in  (input  vblnk);
  modport out (output vblnk);

endinterface

// File: rtl/cfg_shadow_regs.sv
// Shadow/active register pairs: writes land in the shadows, the apply strobe
// copies all three shadows into the active outputs at once.
module cfg_shadow_regs
  import vga_pkg::*;
#(
  parameter logic [COLOR_W-1:0] FRAME_COLOR_INIT = 12'h0_0_0,
  parameter logic [POS_W-1:0]   RECT_X_INIT      = 12'd0,
  parameter logic [POS_W-1:0]   RECT_Y_INIT      = 12'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  cfg_addr_e             i_addr,
  input  logic [CFG_DATA_W-1:0] i_data,
  input  logic                  i_apply,
  output logic [COLOR_W-1:0]    o_frame_color,
  output logic [POS_W-1:0]      o_rect_xpos,
  output logic [POS_W-1:0]      o_rect_ypos
);

  logic [COLOR_W-1:0] r_sh_color;
  logic [POS_W-1:0]   r_sh_x;
  logic [POS_W-1:0]   r_sh_y;
  logic [COLOR_W-1:0] r_color;
  logic [POS_W-1:0]   r_x;
  logic [POS_W-1:0]   r_y;

  // Shadow bank: last write per address wins; reserved address is a no-op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sh_color <= FRAME_COLOR_INIT;
      r_sh_x     <= RECT_X_INIT;
      r_sh_y     <= RECT_Y_INIT;
    end else if (i_we) begin
      case (i_addr)
        CFG_FRAME_COLOR: r_sh_color <= i_data;
        CFG_RECT_X:      r_sh_x     <= i_data;
        CFG_RECT_Y:      r_sh_y     <= i_data;
        default:         ;
      endcase
    end
  end

  // Active bank: only moves on the apply strobe, so it is stable all frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_color <= FRAME_COLOR_INIT;
      r_x     <= RECT_X_INIT;
      r_y     <= RECT_Y_INIT;
    end else if (i_apply) begin
      r_color <= r_sh_color;
      r_x     <= r_sh_x;
      r_y     <= r_sh_y;
    end
  end

  assign o_frame_color = r_color;
  assign o_rect_xpos   = r_x;
  assign o_rect_ypos   = r_y;

endmodule

// File: rtl/draw_cfg_ctl.sv
// Frame-synchronous config controller: collects writes during the frame and
// applies them in a single cycle after the vblnk rising edge.
module draw_cfg_ctl
  import vga_pkg::*;
#(
  parameter logic [COLOR_W-1:0] FRAME_COLOR_INIT = 12'h0_0_0,
  parameter logic [POS_W-1:0]   RECT_X_INIT      = 12'd0,
  parameter logic [POS_W-1:0]   RECT_Y_INIT      = 12'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_if.in                      vga_in,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [1:0]             cfg_addr,
  input  logic [CFG_DATA_W-1:0]  cfg_data,
  output logic [COLOR_W-1:0]     frame_color,
  output logic [POS_W-1:0]       rect_xpos,
  output logic [POS_W-1:0]       rect_ypos,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StApply   = 2'd2
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_load;      // APPLY was entered with shadow writes outstanding
  logic                   w_load_nxt;
  logic                   r_vblnk;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  cfg_addr_e w_addr;
  logic      w_hs;
  logic      w_hs_live;
  logic      w_vblnk_rise;
  logic      w_apply;

  assign w_addr       = cfg_addr_e'(cfg_addr);
  assign w_hs         = cfg_valid && cfg_ready;
  assign w_hs_live    = w_hs && (w_addr != CFG_RSVD);
  assign w_vblnk_rise = vga_in.vblnk && !r_vblnk;

  // State register, apply-load flag and vblnk history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_load  <= 1'b0;
      r_vblnk <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= w_load_nxt;
      r_vblnk <= vga_in.vblnk;
    end
  end

  // Next state; a write in the edge cycle still counts toward this apply.
  always_comb begin
    w_state_nxt = r_state;
    w_load_nxt  = r_load;
    case (r_state)
      StIdle: begin
        if (w_vblnk_rise) begin
          w_state_nxt = StApply;
          w_load_nxt  = w_hs_live;
        end else if (w_hs_live) begin
          w_state_nxt = StPending;
        end
      end
      StPending: begin
        if (w_vblnk_rise) begin
          w_state_nxt = StApply;
          w_load_nxt  = 1'b1;
        end
      end
      StApply: begin
        w_state_nxt = StIdle;
        w_load_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = StIdle;
        w_load_nxt  = 1'b0;
      end
    endcase
  end

  // Outputs decoded from state; reset forces the handshake and tick low.
  always_comb begin
    cfg_ready  = rst && (r_state != StApply);
    frame_tick = rst && (r_state == StApply);
    w_apply    = frame_tick && r_load;
  end

  // Frame counter, wraps naturally at 2^16.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (frame_tick) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;

  cfg_shadow_regs #(
    .FRAME_COLOR_INIT (FRAME_COLOR_INIT),
    .RECT_X_INIT      (RECT_X_INIT),
    .RECT_Y_INIT      (RECT_Y_INIT)
  ) u_shadow (
    .clk           (clk),
    .rst           (rst),
    .i_we          (w_hs),
    .i_addr        (w_addr),
    .i_data        (cfg_data),
    .i_apply       (w_apply),
    .o_frame_color (frame_color),
    .o_rect_xpos   (rect_xpos),
    .o_rect_ypos   (rect_ypos)
  );

endmodule

// File: tb/tb_draw_cfg_ctl.sv
// Bench for draw_cfg_ctl: hand-computed vector table, frame-level corner
// sequences and a randomized run against a frame-event reference model.
module tb_draw_cfg_ctl;

  localparam logic [11:0] COLOR_INIT = 12'h000;
  localparam logic [11:0] X_INIT     = 12'd0;
  localparam logic [11:0] Y_INIT     = 12'd0;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic [11:0] frame_color;
  logic [11:0] rect_xpos;
  logic [11:0] rect_ypos;
  logic        frame_tick;
  logic [15:0] frame_cnt;

  vga_if vga ();

  draw_cfg_ctl #(
    .FRAME_COLOR_INIT (COLOR_INIT),
    .RECT_X_INIT      (X_INIT),
    .RECT_Y_INIT      (Y_INIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_in      (vga),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .frame_color (frame_color),
    .rect_xpos   (rect_xpos),
    .rect_ypos   (rect_ypos),
    .frame_tick  (frame_tick),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;
  int n_ticks  = 0;

  // Values sampled mid-cycle by step().
  logic [11:0] act_color, act_x, act_y;
  logic        act_tick, act_ready;
  logic [15:0] act_cnt;

  // Reference model, thought of per frame: field values written this frame,
  // the values on screen, and whether a frame boundary apply is in flight.
  logic [11:0] m_next[3];
  logic [11:0] m_shown[3];
  bit          m_dirty;
  bit          m_apply;
  bit          m_apply_new;
  bit          m_vb_prev;
  logic [15:0] m_cnt;

  typedef struct {
    logic        r, v;
    logic [1:0]  a;
    logic [11:0] d;
    logic        vb;
    logic [11:0] color, x, y;
    logic        tick, ready;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic r, logic v, logic [1:0] a, logic [11:0] d, logic vb,
                              logic [11:0] color, logic [11:0] x, logic [11:0] y,
                              logic tick, logic ready, logic [15:0] cnt);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.d = d; t.vb = vb;
    t.color = color; t.x = x; t.y = y; t.tick = tick; t.ready = ready; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the reference by one clock with the given inputs.
  task automatic model_edge(input logic r, input logic v, input logic [1:0] a,
                            input logic [11:0] d, input logic vb);
    bit rise;
    if (!r) begin
      m_next[0] = COLOR_INIT; m_next[1] = X_INIT; m_next[2] = Y_INIT;
      m_shown   = m_next;
      m_dirty   = 0; m_apply = 0; m_apply_new = 0; m_vb_prev = 0; m_cnt = 0;
    end else begin
      rise      = vb && !m_vb_prev;
      m_vb_prev = vb;
      if (m_apply) begin
        if (m_apply_new) m_shown = m_next;
        m_cnt   = m_cnt + 16'd1;
        m_apply = 0;
      end else begin
        if (v && a != 2'd3) begin
          m_next[a] = d;
          m_dirty   = 1;
        end
        if (rise) begin
          m_apply     = 1;
          m_apply_new = m_dirty;
          m_dirty     = 0;
        end
      end
    end
  endtask

  // Drive one cycle (caller sits just after a falling edge), sample outputs,
  // optionally compare against the model, then advance to the next falling edge.
  task automatic step(input logic r, input logic v, input logic [1:0] a,
                      input logic [11:0] d, input logic vb, input bit use_model);
    rst = r; cfg_valid = v; cfg_addr = a; cfg_data = d; vga.vblnk = vb;
    #1;
    act_color = frame_color; act_x = rect_xpos; act_y = rect_ypos;
    act_tick  = frame_tick;  act_ready = cfg_ready; act_cnt = frame_cnt;
    if (act_tick === 1'b1) n_ticks++;
    if (use_model) begin
      chk("color", {4'h0, act_color}, {4'h0, m_shown[0]});
      chk("xpos",  {4'h0, act_x},     {4'h0, m_shown[1]});
      chk("ypos",  {4'h0, act_y},     {4'h0, m_shown[2]});
      chk("tick",  {15'h0, act_tick},  {15'h0, r && m_apply});
      chk("ready", {15'h0, act_ready}, {15'h0, r && !m_apply});
      chk("cnt",   act_cnt, m_cnt);
    end
    model_edge(r, v, a, d, vb);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        vb_cur;
    logic [15:0] c0;
    clk = 1'b0; rst = 1'b0; cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 12'h0;
    vga.vblnk = 1'b0;

    tbl[0]  = mk(0, 0, 0, 12'h000, 0, 12'h000, 12'd0,   12'd0,  0, 0, 16'd0);
    tbl[1]  = mk(1, 0, 0, 12'h000, 0, 12'h000, 12'd0,   12'd0,  0, 1, 16'd0);
    tbl[2]  = mk(1, 1, 0, 12'hF00, 0, 12'h000, 12'd0,   12'd0,  0, 1, 16'd0);
    tbl[3]  = mk(1, 0, 0, 12'h000, 0, 12'h000, 12'd0,   12'd0,  0, 1, 16'd0);
    tbl[4]  = mk(1, 0, 0, 12'h000, 1, 12'h000, 12'd0,   12'd0,  0, 1, 16'd0);
    tbl[5]  = mk(1, 0, 0, 12'h000, 1, 12'h000, 12'd0,   12'd0,  1, 0, 16'd0);
    tbl[6]  = mk(1, 0, 0, 12'h000, 1, 12'hF00, 12'd0,   12'd0,  0, 1, 16'd1);
    tbl[7]  = mk(1, 0, 0, 12'h000, 0, 12'hF00, 12'd0,   12'd0,  0, 1, 16'd1);
    tbl[8]  = mk(1, 1, 1, 12'd100, 0, 12'hF00, 12'd0,   12'd0,  0, 1, 16'd1);
    tbl[9]  = mk(1, 1, 1, 12'd200, 0, 12'hF00, 12'd0,   12'd0,  0, 1, 16'd1);
    tbl[10] = mk(1, 1, 3, 12'hABC, 0, 12'hF00, 12'd0,   12'd0,  0, 1, 16'd1);
    tbl[11] = mk(1, 0, 0, 12'h000, 1, 12'hF00, 12'd0,   12'd0,  0, 1, 16'd1);
    tbl[12] = mk(1, 0, 0, 12'h000, 1, 12'hF00, 12'd0,   12'd0,  1, 0, 16'd1);
    tbl[13] = mk(1, 0, 0, 12'h000, 1, 12'hF00, 12'd200, 12'd0,  0, 1, 16'd2);
    tbl[14] = mk(1, 0, 0, 12'h000, 0, 12'hF00, 12'd200, 12'd0,  0, 1, 16'd2);
    tbl[15] = mk(1, 1, 2, 12'd50,  1, 12'hF00, 12'd200, 12'd0,  0, 1, 16'd2);
    tbl[16] = mk(1, 1, 0, 12'h123, 1, 12'hF00, 12'd200, 12'd0,  1, 0, 16'd2);
    tbl[17] = mk(1, 0, 0, 12'h000, 0, 12'hF00, 12'd200, 12'd50, 0, 1, 16'd3);
    tbl[18] = mk(1, 0, 0, 12'h000, 1, 12'hF00, 12'd200, 12'd50, 0, 1, 16'd3);
    tbl[19] = mk(1, 0, 0, 12'h000, 1, 12'hF00, 12'd200, 12'd50, 1, 0, 16'd3);
    tbl[20] = mk(1, 0, 0, 12'h000, 1, 12'hF00, 12'd200, 12'd50, 0, 1, 16'd4);

    // Power-up reset; outputs are undefined until the first edge.
    step(0, 0, 0, 12'h0, 0, 0);
    step(0, 0, 0, 12'h0, 0, 0);

    // Hand-computed vectors: reset release, deferred apply, last write wins,
    // reserved address, write in the edge cycle, write attempt during apply.
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].vb, 0);
      chk($sformatf("tbl%0d.color", i), {4'h0, act_color}, {4'h0, tbl[i].color});
      chk($sformatf("tbl%0d.xpos", i),  {4'h0, act_x},     {4'h0, tbl[i].x});
      chk($sformatf("tbl%0d.ypos", i),  {4'h0, act_y},     {4'h0, tbl[i].y});
      chk($sformatf("tbl%0d.tick", i),  {15'h0, act_tick},  {15'h0, tbl[i].tick});
      chk($sformatf("tbl%0d.ready", i), {15'h0, act_ready}, {15'h0, tbl[i].ready});
      chk($sformatf("tbl%0d.cnt", i),   act_cnt, tbl[i].cnt);
    end

    // Long vblnk pulses: one tick per frame, no writes so outputs hold.
    c0      = m_cnt;
    n_ticks = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 10; k++) step(1, 0, 0, 12'h0, 0, 1);
      for (int k = 0; k < 45; k++) step(1, 0, 0, 12'h0, 1, 1);
    end
    step(1, 0, 0, 12'h0, 0, 1);
    chk("long_vblnk.ticks", 16'(n_ticks), 16'd3);
    chk("long_vblnk.cnt", act_cnt, c0 + 16'd3);
    chk("long_vblnk.color", {4'h0, act_color}, 16'h0F00);

    // Reset between a write and the frame edge discards the write.
    step(1, 1, 2, 12'd77, 0, 1);
    step(0, 0, 0, 12'h0,  0, 1);
    step(1, 0, 0, 12'h0,  0, 1);
    chk("rst_release.ready", {15'h0, act_ready}, 16'd1);
    step(1, 0, 0, 12'h0,  1, 1);
    step(1, 0, 0, 12'h0,  1, 1);
    step(1, 0, 0, 12'h0,  0, 1);
    chk("rst_discard.ypos", {4'h0, act_y}, {4'h0, Y_INIT});
    chk("rst_discard.color", {4'h0, act_color}, {4'h0, COLOR_INIT});

    // Reset landing on the apply cycle cancels it.
    step(1, 1, 0, 12'h0F0, 0, 1);
    step(1, 0, 0, 12'h0,   1, 1);
    step(0, 0, 0, 12'h0,   1, 1);
    chk("rst_in_apply.tick", {15'h0, act_tick}, 16'd0);
    step(1, 0, 0, 12'h0,   0, 1);
    chk("rst_in_apply.color", {4'h0, act_color}, {4'h0, COLOR_INIT});

    // Counter wrap: preload to all-ones, then one frame.
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    m_cnt = 16'hFFFF;
    step(1, 0, 0, 12'h0, 0, 1);
    chk("wrap.preload", act_cnt, 16'hFFFF);
    step(1, 0, 0, 12'h0, 1, 1);
    step(1, 0, 0, 12'h0, 1, 1);
    step(1, 0, 0, 12'h0, 0, 1);
    chk("wrap.cnt", act_cnt, 16'h0000);

    // Randomized traffic against the model.
    vb_cur = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) vb_cur = ~vb_cur;
      step(($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           12'($urandom), vb_cur, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
